// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell and a borrow flop.
// Optional signed-overflow flag is compiled in with SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             brw;
    logic             borrow_q;
    logic             accept;
    logic             last;
    logic             d;
    logic             bo;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    function automatic logic cell_d(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic cell_bo(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    always_comb begin
        accept   = ((state == IDLE) || (state == DONE)) && bus.start;
        last     = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
        d        = cell_d(a_sr[0], b_sr[0], brw);
        bo       = cell_bo(a_sr[0], b_sr[0], brw);
        // Result bits arrive LSB first; the final bit completes the word without an extra shift.
        res_next = {d, res_sr};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            brw      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (accept) begin
            cnt      <= '0;
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            res_sr   <= '0;
            brw      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            cnt    <= cnt + 1'b1;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next[WIDTH-1:1];
            brw    <= bo;
            if (last) begin
                diff_q   <= res_next;
                borrow_q <= bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q    <= (a_msb != b_msb) && (d != a_msb);
`endif
            end
        end
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8) plus a WIDTH=4 exhaustive sweep.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    logic [7:0] last_diff;
    logic       last_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       last_ovf;
`endif

    serial_subtractor_if #(.WIDTH(8)) s8 ();
    serial_subtractor_if #(.WIDTH(4)) s4 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .reset(reset), .bus(s8.slave));
    serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .reset(reset), .bus(s4.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation from IDLE; optionally wiggles start/a/b during SHIFT.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit disturb);
        logic [7:0] ed;
        logic       eb;
        ed = x - y;
        eb = (x < y);
        s8.start = 1'b1;
        s8.a = x;
        s8.b = y;
        tick();
        s8.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("shift_busy_done_diff", {s8.busy, s8.done, s8.diff}, {1'b1, 1'b0, last_diff});
            if (disturb && (i == 2 || i == 5)) begin
                s8.start = 1'b1;
                s8.a = 8'($urandom);
                s8.b = 8'($urandom);
            end else begin
                s8.start = 1'b0;
            end
            tick();
        end
        check("done_pulse", {s8.busy, s8.done}, 2'b01);
        check("diff", s8.diff, ed);
        check("borrow", s8.borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
        begin
            int  sd;
            logic eo;
            sd = int'($signed(x)) - int'($signed(y));
            eo = (sd > 127) || (sd < -128);
            check("ovf", s8.ovf, eo);
            last_ovf = eo;
        end
`endif
        last_diff = ed;
        last_borrow = eb;
        tick();
        check("done_falls", {s8.busy, s8.done, s8.diff, s8.borrow}, {2'b00, last_diff, last_borrow});
    endtask

    initial begin
        reset = 1'b1;
        s8.start = 1'b0; s8.a = '0; s8.b = '0;
        s4.start = 1'b0; s4.a = '0; s4.b = '0;
        last_diff = '0;
        last_borrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        last_ovf = 1'b0;
`endif
        tick();
        tick();
        check("reset_state8", {s8.busy, s8.done, s8.diff, s8.borrow}, 11'd0);
        check("reset_state4", {s4.busy, s4.done, s4.diff, s4.borrow}, 7'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", s8.ovf, 1'b0);
`endif
        reset = 1'b0;
        tick();

        run8(8'd5, 8'd3, 1'b0);
        run8(8'd3, 8'd5, 1'b0);
        run8(8'd0, 8'd0, 1'b0);
        run8(8'h80, 8'h01, 1'b0);
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'h7F, 8'hFF, 1'b0);
        run8(8'hFF, 8'h00, 1'b0);

        run8(8'hC3, 8'h5A, 1'b1);
        run8(8'h11, 8'hEE, 1'b1);

        // start held high: accept on each DONE cycle
        s8.start = 1'b1;
        s8.a = 8'hFF;
        s8.b = 8'h0F;
        tick();
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 8; i++) begin
                check("held_busy", {s8.busy, s8.done}, 2'b10);
                tick();
            end
            check("held_done", {s8.busy, s8.done, s8.diff, s8.borrow}, {2'b01, 8'hF0, 1'b0});
            tick();
        end
        s8.start = 1'b0;
        last_diff = 8'hF0;
        last_borrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        last_ovf = 1'b0;
`endif
        repeat (9) tick();
        check("held_idle", {s8.busy, s8.done, s8.diff}, {2'b00, 8'hF0});

        // reset on the 4th SHIFT cycle aborts with no done
        s8.start = 1'b1;
        s8.a = 8'h9C;
        s8.b = 8'h21;
        tick();
        s8.start = 1'b0;
        repeat (3) tick();
        check("pre_reset_busy", s8.busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", {s8.busy, s8.done, s8.diff, s8.borrow}, 11'd0);
        last_diff = '0;
        last_borrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        last_ovf = 1'b0;
        check("abort_ovf", s8.ovf, 1'b0);
`endif
        begin
            int dones;
            dones = 0;
            for (int i = 0; i < 12; i++) begin
                if (s8.done === 1'b1 || s8.busy === 1'b1) dones++;
                tick();
            end
            check("abort_no_done", dones, 0);
        end
        run8(8'd10, 8'd4, 1'b0);

        for (int k = 0; k < 24; k++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // exhaustive WIDTH=4 sweep, back-to-back through DONE
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [3:0] ed4;
                ed4 = 4'(x - y);
                s4.start = 1'b1;
                s4.a = 4'(x);
                s4.b = 4'(y);
                tick();
                s4.start = 1'b0;
                repeat (4) tick();
                check("sweep4", {s4.busy, s4.done, s4.borrow, s4.diff},
                      {2'b01, (x < y) ? 1'b1 : 1'b0, ed4});
            end
        end
        tick();
        check("sweep4_idle", {s4.busy, s4.done, s4.diff}, {2'b00, 4'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
